div_radix2: RTL
===============

# div_radix2

Multi-cycle radix-2 restoring divider for the execute stage, serving MIPS `DIV`/`DIVU`. It produces the divider stall request that the hazard unit turns into `stallE`/`stallD`/`stallF`, and it delivers the 64-bit `{remainder, quotient}` pair to the HI/LO write path. It honours exception flushes and external (data-side) pipeline stalls, so each instruction is divided exactly once.

## Interface
Parameters:
- `WIDTH`, 32, operand width; the result is `2*WIDTH`.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `signed_div_i`  in  1  1 = `DIV` (two's complement), 0 = `DIVU`.
- `opdata1_i`  in  WIDTH  dividend (rs).
- `opdata2_i`  in  WIDTH  divisor (rt).
- `start_i`  in  1  a divide instruction occupies E; held high by the pipeline while it stays in E.
- `annul_i`  in  1  exception flush (`excepttypeM != 0`); abandons the operation.
- `ex_stall_i`  in  1  non-divider E-stage stall (`d_stall`); must not include `stall_o`.
- `result_o`  out  2*WIDTH  `{remainder, quotient}`, i.e. `{hi, lo}`.
- `ready_o`  out  1  result valid.
- `stall_o`  out  1  `div_stallE` to the hazard unit.

## Operation
- States (2-bit): `IDLE`, `BYZERO`, `ON`, `END`.
- `IDLE`:
  - `start_i & ~annul_i` with divisor != 0 -> `ON`. The cycle also latches |dividend| and |divisor|, `cnt=0`, the sign of the dividend and the XOR of the two signs. Absolute values are taken only when `signed_div_i` is 1.
  - `start_i & ~annul_i` with divisor == 0 -> `BYZERO`.
- `BYZERO`: the result is loaded as quotient `{WIDTH{1'b1}}`, remainder = raw dividend. The next state is `END`.
- `ON` runs one iteration per cycle and increments `cnt`:
  - The partial remainder (WIDTH+1 bits) is shifted left, taking in the next dividend MSB.
  - The divisor is trial-subtracted. If the difference is non-negative, the remainder takes the difference and the quotient bit is 1; otherwise the quotient bit is 0.
  - After iteration `cnt == WIDTH-1` the state becomes `END`, and the result register is loaded with the sign-fixed values:
    - quotient negated if the XOR of the signs = 1;
    - remainder negated if the dividend was negative;
    - signed only.
  - All arithmetic is modulo 2^WIDTH. `0x80000000 / -1` yields quotient `0x80000000`, remainder 0.
- `END`:
  - `ready_o=1`.
  - If `ex_stall_i` is high, stay in `END` and hold `result_o`. Otherwise go to `IDLE`.
- `annul_i` in any state -> `IDLE` next cycle, with no `ready_o`. `result_o` keeps its last value.
- `rst` has priority over everything. It forces `IDLE`, `cnt=0`, `result_o=0`, `ready_o=0`.
- `stall_o = start_i & ~annul_i & (state != END)`. This is combinational, so the stall is raised in the same cycle the divide enters E.
- `ready_o = (state == END)`. This is registered-state decoded with no combinational input path.

## Timing
- Reset values: `state=IDLE`, `result_o=0`, `ready_o=0`. `stall_o` follows its equation (0 while `start_i=0`).
- Normal divide with `start_i` sampled in `IDLE` at cycle T:
  - `ON` runs T+1..T+WIDTH.
  - `END` and `ready_o=1` at T+WIDTH+1 (T+33).
  - `stall_o` is high T..T+32 and low at T+33, so the instruction advances to M with the result.
- Divide by zero: `BYZERO` at T+1, `END`/`ready_o` at T+2, `stall_o` high T..T+1.
- Back-to-back divides:
  - After `END -> IDLE`, the next `start_i` is accepted in that `IDLE` cycle.
  - The minimum spacing is WIDTH+2 cycles per divide.
- Held in `END` by `ex_stall_i`: `start_i` remains high but is ignored. No restart occurs, and `result_o`/`ready_o` are stable.
- `annul_i` and `start_i` in the same `IDLE` cycle: the start is not accepted and `stall_o=0`.
- Operands are sampled only in the accept cycle. Later changes on `opdata*_i` have no effect.

## Structure
- Shared package `div_pkg`:
  - state encodings `DIV_IDLE=2'b00`, `DIV_BYZERO=2'b01`, `DIV_ON=2'b10`, `DIV_END=2'b11`;
  - `DIV_CNT_W = $clog2(WIDTH)`.
- One sub-module: `div_sign_fix`, combinational. It performs the conditional two's-complement negate, instantiated for the pre-abs of both operands and the post-fix of both results.
- The iteration datapath and FSM live in `div_radix2` itself.

## Test plan
- Unsigned 100 / 7, start at T:
  - `stall_o` high T..T+32.
  - `ready_o` at T+33 with `result_o = {32'd2, 32'd14}`.
- Signed -7 / 2 → `result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}`. Signed 7 / -2 → `{32'd1, 32'hFFFFFFFD}`.
- Signed `0x80000000 / 0xFFFFFFFF` → `{32'd0, 32'h80000000}`. Unsigned `0xFFFFFFFF / 1` → `{0, 0xFFFFFFFF}`.
- Divide 5 / 0 → `ready_o` at T+2, `result_o = {32'd5, 32'hFFFFFFFF}`, `stall_o` low at T+2.
- `annul_i` pulse at T+10:
  - `stall_o` low at T+10, `IDLE` at T+11, no `ready_o` pulse.
  - A new 9/3 started at T+12 yields `{0, 3}` at T+45.
- `ex_stall_i` high for 3 cycles in `END`: `ready_o`/`result_o` held 4 cycles, with no second computation. A `rst` asserted at T+5 of a divide leads to `IDLE`, `result_o=0`, `ready_o=0` next cycle.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the radix-2 restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_radix2_if.sv
// Pipeline <-> divider bundle: operands, control and result/handshake.
interface div_radix2_if #(parameter int WIDTH = 32);

    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic                 ex_stall_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 stall_o;

    // Pipeline side drives the request and consumes the result.
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i, ex_stall_i,
        input  result_o, ready_o, stall_o
    );

    // Divider side.
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i, ex_stall_i,
        output result_o, ready_o, stall_o
    );

endinterface

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate (modulo 2^WIDTH).
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? ((~a) + WIDTH'(1)) : a;

endmodule

// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result is {rem, quo}.
module div_radix2
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    div_radix2_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    div_state_e           state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     rem;      // partial remainder, always < divisor
    logic [WIDTH-1:0]     quo;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]     dvs;
    logic                 neg_rem;
    logic                 neg_quo;
    logic [2*WIDTH-1:0]   result;

    logic                 accept;
    logic                 dvs_zero;
    logic                 sgn1, sgn2;
    logic [WIDTH-1:0]     abs1, abs2;
    logic [WIDTH:0]       rem_sh, diff;
    logic                 qbit;
    logic [WIDTH-1:0]     rem_nxt, quo_nxt;
    logic [WIDTH-1:0]     rem_fix, quo_fix;

    assign accept   = bus.start_i & ~bus.annul_i;
    assign dvs_zero = (bus.opdata2_i == '0);
    assign sgn1     = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    assign sgn2     = bus.signed_div_i & bus.opdata2_i[WIDTH-1];

    // Operand magnitudes; only negated for signed divides.
    div_sign_fix #(.WIDTH(WIDTH)) u_abs1 (.a(bus.opdata1_i), .neg(sgn1), .y(abs1));
    div_sign_fix #(.WIDTH(WIDTH)) u_abs2 (.a(bus.opdata2_i), .neg(sgn2), .y(abs2));

    // One restoring step: shift in the next dividend bit, trial-subtract.
    assign rem_sh  = {rem, quo[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, dvs};
    assign qbit    = ~diff[WIDTH];
    assign rem_nxt = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], qbit};

    // Final sign correction applied on the last iteration.
    div_sign_fix #(.WIDTH(WIDTH)) u_fixq (.a(quo_nxt), .neg(neg_quo), .y(quo_fix));
    div_sign_fix #(.WIDTH(WIDTH)) u_fixr (.a(rem_nxt), .neg(neg_rem), .y(rem_fix));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; an exception flush overrides every state.
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE:   if (accept) state_nxt = dvs_zero ? DIV_BYZERO : DIV_ON;
            DIV_BYZERO: state_nxt = DIV_END;
            DIV_ON:     if (cnt == LAST) state_nxt = DIV_END;
            DIV_END:    if (!bus.ex_stall_i) state_nxt = DIV_IDLE;
            default:    state_nxt = DIV_IDLE;
        endcase
        if (bus.annul_i) state_nxt = DIV_IDLE;
    end

    // Datapath: latch operands on accept, iterate, load the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            neg_rem <= 1'b0;
            neg_quo <= 1'b0;
            result  <= '0;
        end else if (!bus.annul_i) begin
            case (state)
                DIV_IDLE: if (bus.start_i) begin
                    cnt     <= '0;
                    rem     <= '0;
                    dvs     <= abs2;
                    // divide-by-zero reports the raw dividend as remainder
                    quo     <= dvs_zero ? bus.opdata1_i : abs1;
                    neg_rem <= sgn1;
                    neg_quo <= sgn1 ^ sgn2;
                end
                DIV_BYZERO: result <= {quo, {WIDTH{1'b1}}};
                DIV_ON: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) result <= {rem_fix, quo_fix};
                end
                default: ;
            endcase
        end
    end

    assign bus.result_o = result;
    assign bus.ready_o  = (state == DIV_END);
    assign bus.stall_o  = accept & (state != DIV_END);

endmodule
